// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin sensor synchroniser, debouncer and pulse-width classifier
// Classifies debounced coin pulses as 5 Rs / 10 Rs and strobes reject for bad, early, locked-out or jammed coins.
module coin_acceptor #(
  parameter int CNT_W   = 16,
  parameter int DB_LEN  = 4,
  parameter int T5_MIN  = 100,
  parameter int T5_MAX  = 199,
  parameter int T10_MIN = 200,
  parameter int T10_MAX = 399,
  parameter int JAM_LEN = 1000,
  parameter int GAP_LEN = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_sense,
  input  logic       lockout,
  output logic [1:0] coin_code,
  output logic       coin_valid,
  output logic       reject,
  output logic       jam,
  output logic [7:0] coin_count
);

  typedef enum logic [2:0] {IDLE, MEASURE, CLASSIFY, GAP, JAM} state_t;

  localparam int DBW = $clog2(DB_LEN + 1);
  localparam logic [DBW-1:0]   DB_LAST = DBW'(DB_LEN - 1);
  localparam logic [CNT_W-1:0] W5_MIN  = CNT_W'(T5_MIN);
  localparam logic [CNT_W-1:0] W5_MAX  = CNT_W'(T5_MAX);
  localparam logic [CNT_W-1:0] W10_MIN = CNT_W'(T10_MIN);
  localparam logic [CNT_W-1:0] W10_MAX = CNT_W'(T10_MAX);
  localparam logic [CNT_W-1:0] W_JAM   = CNT_W'(JAM_LEN);
  localparam logic [CNT_W-1:0] W_GAP   = CNT_W'(GAP_LEN);

  logic           sync1, sync2, db;
  logic [DBW-1:0] db_cnt;

  state_t           state, nxt_state;
  logic [CNT_W-1:0] width, nxt_width, width_inc;
  logic [CNT_W-1:0] gap, nxt_gap, gap_inc;
  logic             early, nxt_early;
  logic [1:0]       nxt_code;
  logic             nxt_valid, nxt_reject, nxt_jam;

  // db flips only after DB_LEN consecutive synced samples disagree with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db     <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= coin_sense;
      sync2 <= sync1;
      if (sync2 != db) begin
        if (db_cnt == DB_LAST) begin
          db     <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign width_inc = (width == '1) ? width : width + 1'b1;
  assign gap_inc   = (gap == '1) ? gap : gap + 1'b1;

  always_comb begin
    nxt_state  = state;
    nxt_width  = width;
    nxt_gap    = gap;
    nxt_early  = early;
    nxt_code   = 2'b00;
    nxt_valid  = 1'b0;
    nxt_reject = 1'b0;
    nxt_jam    = jam;
    case (state)
      IDLE: begin
        if (db) begin
          nxt_state = MEASURE;
          nxt_width = CNT_W'(1);
          nxt_early = 1'b0;
        end
      end
      MEASURE: begin
        if (db) begin
          nxt_width = width_inc;
          if (width_inc >= W_JAM) begin
            nxt_state  = JAM;
            nxt_reject = 1'b1;
            nxt_jam    = 1'b1;
            nxt_gap    = '0;
          end
        end else begin
          nxt_state = CLASSIFY;
        end
      end
      CLASSIFY: begin
        nxt_state = GAP;
        nxt_gap   = '0;
        if (early || lockout) begin
          nxt_reject = 1'b1;
        end else if (width >= W5_MIN && width <= W5_MAX) begin
          nxt_code  = 2'b01;
          nxt_valid = 1'b1;
        end else if (width >= W10_MIN && width <= W10_MAX) begin
          nxt_code  = 2'b10;
          nxt_valid = 1'b1;
        end else begin
          nxt_reject = 1'b1;
        end
      end
      GAP: begin
        if (db) begin
          nxt_state = MEASURE;
          nxt_width = CNT_W'(1);
          nxt_early = 1'b1;
        end else begin
          nxt_gap = gap_inc;
          if (gap_inc >= W_GAP) nxt_state = IDLE;
        end
      end
      JAM: begin
        if (db) begin
          nxt_gap = '0;
        end else begin
          nxt_gap = gap_inc;
          if (gap_inc >= W_GAP) begin
            nxt_state = IDLE;
            nxt_jam   = 1'b0;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      width      <= '0;
      gap        <= '0;
      early      <= 1'b0;
      coin_code  <= 2'b00;
      coin_valid <= 1'b0;
      reject     <= 1'b0;
      jam        <= 1'b0;
      coin_count <= 8'd0;
    end else begin
      state      <= nxt_state;
      width      <= nxt_width;
      gap        <= nxt_gap;
      early      <= nxt_early;
      coin_code  <= nxt_code;
      coin_valid <= nxt_valid;
      reject     <= nxt_reject;
      jam        <= nxt_jam;
      if (nxt_valid) coin_count <= coin_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - directed self-checking bench for coin_acceptor
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_sense = 1'b0;
  logic       lockout = 1'b0;
  logic [1:0] coin_code;
  logic       coin_valid, reject, jam;
  logic [7:0] coin_count;

  int checks = 0;
  int errors = 0;

  int n_valid = 0;
  int n_reject = 0;
  int n_bad = 0;
  logic [1:0] last_code = 2'b00;

  coin_acceptor dut (
    .clk(clk), .rst_n(rst_n), .coin_sense(coin_sense), .lockout(lockout),
    .coin_code(coin_code), .coin_valid(coin_valid), .reject(reject),
    .jam(jam), .coin_count(coin_count)
  );

  always #5 clk = ~clk;

  // Cumulative strobe monitor; tasks compare before/after snapshots
  always @(negedge clk) begin
    if (coin_valid) begin
      n_valid++;
      last_code = coin_code;
    end
    if (reject) n_reject++;
    if ((coin_valid && reject) || (!coin_valid && coin_code != 2'b00) || coin_code == 2'b11) n_bad++;
  end

  task automatic drive_pulse(input int w, input int settle);
    @(negedge clk);
    coin_sense = 1'b1;
    repeat (w) @(negedge clk);
    coin_sense = 1'b0;
    repeat (settle) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({coin_code, coin_valid, reject, jam, coin_count} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b expected=0", {coin_code, coin_valid, reject, jam, coin_count});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_coin5;
    int v0, r0;
    logic [7:0] c0;
    v0 = n_valid; r0 = n_reject; c0 = coin_count;
    drive_pulse(150, 75);
    checks++;
    if (n_valid - v0 !== 1 || last_code !== 2'b01) begin
      errors++;
      $display("FAIL coin5_valid got=%0d code=%b expected=1 code=01", n_valid - v0, last_code);
    end
    checks++;
    if (n_reject - r0 !== 0) begin
      errors++;
      $display("FAIL coin5_reject got=%0d expected=0", n_reject - r0);
    end
    checks++;
    if (coin_count !== c0 + 8'd1) begin
      errors++;
      $display("FAIL coin5_count got=%0d expected=%0d", coin_count, c0 + 8'd1);
    end
  endtask

  task automatic test_widths;
    int widths[6] = '{300, 99, 199, 200, 399, 400};
    logic [1:0] codes[6] = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 6; i++) begin
      int v0, r0, ev, er;
      logic [7:0] c0;
      v0 = n_valid; r0 = n_reject; c0 = coin_count;
      ev = (codes[i] != 2'b00) ? 1 : 0;
      er = 1 - ev;
      drive_pulse(widths[i], 75);
      checks++;
      if (n_valid - v0 !== ev || n_reject - r0 !== er || (ev == 1 && last_code !== codes[i])) begin
        errors++;
        $display("FAIL width_%0d got valid=%0d reject=%0d code=%b expected valid=%0d reject=%0d code=%b",
                 widths[i], n_valid - v0, n_reject - r0, last_code, ev, er, codes[i]);
      end
      checks++;
      if (coin_count !== c0 + 8'(ev)) begin
        errors++;
        $display("FAIL width_%0d_count got=%0d expected=%0d", widths[i], coin_count, c0 + 8'(ev));
      end
    end
  endtask

  task automatic test_lockout;
    int v0, r0;
    logic [7:0] c0;
    v0 = n_valid; r0 = n_reject; c0 = coin_count;
    lockout = 1'b1;
    drive_pulse(150, 75);
    lockout = 1'b0;
    checks++;
    if (n_valid - v0 !== 0 || n_reject - r0 !== 1) begin
      errors++;
      $display("FAIL lockout got valid=%0d reject=%0d expected valid=0 reject=1", n_valid - v0, n_reject - r0);
    end
    checks++;
    if (coin_count !== c0) begin
      errors++;
      $display("FAIL lockout_count got=%0d expected=%0d", coin_count, c0);
    end
  endtask

  task automatic test_glitch;
    int v0, r0;
    v0 = n_valid; r0 = n_reject;
    for (int i = 0; i < 4; i++) drive_pulse(3, 10);
    drive_pulse(150, 75);
    checks++;
    if (n_valid - v0 !== 1 || n_reject - r0 !== 0 || last_code !== 2'b01) begin
      errors++;
      $display("FAIL glitch got valid=%0d reject=%0d code=%b expected valid=1 reject=0 code=01",
               n_valid - v0, n_reject - r0, last_code);
    end
  endtask

  task automatic test_back_to_back;
    int v0, r0;
    v0 = n_valid; r0 = n_reject;
    drive_pulse(150, 20);
    drive_pulse(150, 75);
    checks++;
    if (n_valid - v0 !== 1 || n_reject - r0 !== 1) begin
      errors++;
      $display("FAIL early_coin got valid=%0d reject=%0d expected valid=1 reject=1", n_valid - v0, n_reject - r0);
    end
  endtask

  task automatic test_jam;
    int v0, r0, cyc;
    v0 = n_valid; r0 = n_reject;
    @(negedge clk);
    coin_sense = 1'b1;
    repeat (1100) @(negedge clk);
    checks++;
    if (jam !== 1'b1 || n_reject - r0 !== 1) begin
      errors++;
      $display("FAIL jam_set got jam=%b reject=%0d expected jam=1 reject=1", jam, n_reject - r0);
    end
    repeat (100) @(negedge clk);
    coin_sense = 1'b0;
    cyc = 0;
    while (jam === 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 56) begin
      errors++;
      $display("FAIL jam_clear got=%0d cycles expected=56", cyc);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (n_valid - v0 !== 0 || n_reject - r0 !== 1) begin
      errors++;
      $display("FAIL jam_strobes got valid=%0d reject=%0d expected valid=0 reject=1", n_valid - v0, n_reject - r0);
    end
  endtask

  task automatic test_reset_mid_coin;
    int v0, r0;
    @(negedge clk);
    coin_sense = 1'b1;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({coin_code, coin_valid, reject, jam, coin_count} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid got=%b expected=0", {coin_code, coin_valid, reject, jam, coin_count});
    end
    coin_sense = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v0 = n_valid; r0 = n_reject;
    repeat (80) @(negedge clk);
    checks++;
    if (n_valid - v0 !== 0 || n_reject - r0 !== 0) begin
      errors++;
      $display("FAIL reset_no_strobe got valid=%0d reject=%0d expected 0", n_valid - v0, n_reject - r0);
    end
  endtask

  task automatic test_count_wrap;
    for (int i = 0; i < 255; i++) drive_pulse(120, 70);
    checks++;
    if (coin_count !== 8'd255) begin
      errors++;
      $display("FAIL count_255 got=%0d expected=255", coin_count);
    end
    drive_pulse(120, 70);
    checks++;
    if (coin_count !== 8'd0) begin
      errors++;
      $display("FAIL count_wrap got=%0d expected=0", coin_count);
    end
  endtask

  task automatic test_strobe_rules;
    checks++;
    if (n_bad !== 0) begin
      errors++;
      $display("FAIL strobe_rules got=%0d violations expected=0", n_bad);
    end
  endtask

  initial begin
    test_reset;
    test_coin5;
    test_widths;
    test_lockout;
    test_glitch;
    test_back_to_back;
    test_jam;
    test_reset_mid_coin;
    test_count_wrap;
    test_strobe_rules;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
